ppg_afe_calibrator: RTL
=======================

// Module: ppg_afe_calibrator
// PURPOSE
//  Parametrised successor to the two-LED PPG front-end controller. Calibrates DC_Comp and PGA_Gain
//  independently for NUM_CH time-multiplexed LED channels, using windowed averaging and clip detection.
//  It then runs a round-robin operating mode that applies each channel's stored settings and streams
//  tagged ADC samples. Sits between the AFE (LED driver, DC compensation DAC, PGA, ADC) and the SpO2 logic.
// PARAMETERS
//  NUM_CH       2    number of LED channels (ch0=RED, ch1=IR by convention), 1..8
//  ADC_W        8    ADC sample width
//  DC_W         7    DC compensation code width
//  PGA_W        4    PGA gain code width
//  AVG_LOG2     5    DC window = 2**AVG_LOG2 samples
//  SETTLE       4    samples discarded after any LED/DC/PGA change
//  PGA_WIN      16   samples per PGA clip-check window
//  DC_LO/DC_HI  120/130  accepted DC average band (inclusive)
//  CLIP_LO/CLIP_HI  10/245  clip thresholds (min<=CLIP_LO or max>=CLIP_HI = clipped)
//  SLOT_CYC     10   cycles per channel slot in operation
//  LED_CUR      10   fixed LED_DRIVE code
// PORTS
//  CLK            in   1          system clock, all logic on posedge
//  rst_n          in   1          asynchronous active-low reset
//  ADC            in   ADC_W      ADC sample, valid every cycle
//  Find_setting   in   1          1-cycle start/restart calibration pulse
//  LED_DRIVE      out  4          LED current code (=LED_CUR)
//  LED_EN         out  NUM_CH     one-hot LED enable
//  DC_Comp        out  DC_W       DC compensation code to AFE
//  PGA_Gain       out  PGA_W      PGA gain code to AFE
//  CLK_Filter     out  1          CLK/2 filter clock
//  Sample_Value   out  ADC_W      captured sample in operation
//  Sample_Ch      out  clog2(NUM_CH) channel of Sample_Value
//  Sample_Valid   out  1          1-cycle strobe per captured sample
//  Cal_Busy       out  1          calibration in progress
//  Cal_Done       out  1          all channels calibrated, operating
//  Cal_Error      out  NUM_CH     per-channel DC search hit code 0 or max
// BEHAVIOUR
//  Reset: all outputs 0 except LED_DRIVE=LED_CUR; state IDLE; stored settings 0.
//  FSM: IDLE -> (Find_setting) SETTLE -> DC_ACC -> DC_EVAL -> SETTLE/PGA_ACC -> PGA_EVAL -> NEXT_CH -> OPERATE.
//  Find_setting in any state: ch=0, DC_Comp=2**(DC_W-1), PGA_Gain=0, Cal_Done=0, Cal_Error=0, go to SETTLE.
//  SETTLE: count SETTLE cycles with LED_EN=1<<ch, then clear accumulators.
//  DC_ACC: sum ADC for 2**AVG_LOG2 cycles; sum width ADC_W+AVG_LOG2, no overflow; avg = sum>>AVG_LOG2.
//  DC_EVAL (1 cycle): avg<DC_LO -> DC_Comp-1; avg>DC_HI -> DC_Comp+1; then SETTLE.
//   In band -> store DC[ch], PGA_Gain=0, go to SETTLE then PGA_ACC.
//   Step needed but code at 0/max -> set Cal_Error[ch], store code, proceed to PGA.
//  PGA_ACC: track min/max over PGA_WIN cycles (min init all-ones, max init 0).
//  PGA_EVAL: clipped -> store PGA[ch]=PGA_Gain-1 (0 if gain 0), go to NEXT_CH.
//   Unclipped and gain=max -> store max, go to NEXT_CH. Else gain+1, then SETTLE, PGA_ACC.
//  NEXT_CH: ch==NUM_CH-1 -> OPERATE, slot=0, else ch+1, DC_Comp=mid, SETTLE.
//  OPERATE: LED_EN=1<<slot; DC_Comp/PGA_Gain = stored[slot], registered at slot start.
//   Last cycle of each slot: Sample_Value<=ADC, Sample_Ch<=slot, Sample_Valid=1.
//   Slot wraps NUM_CH-1 -> 0. Cal_Done=1 while in OPERATE.
//  Cal_Busy=1 in all states except IDLE/OPERATE. CLK_Filter toggles every cycle, reset 0.
//  Async reset mid-calibration aborts to IDLE; stored settings cleared.
// STRUCTURE
//  Package ppg_afe_pkg: state enum, clog2 helper, default thresholds.
//  Sub-module ppg_win_stats: windowed sum/min/max over a programmable count. Shared by DC and PGA phases.
//  Per-channel DC/PGA storage is a NUM_CH-entry register array.
// TESTING
//  rst_n low mid-DC_ACC -> all outputs reset, LED_DRIVE=10, IDLE until Find_setting.
//  ADC const 125, NUM_CH=2 -> DC stays 64 both ch; PGA raised to 15, stored 15; Cal_Done=1.
//  ADC = 200-DC_Comp model -> DC converges into 120..130, one step per window+SETTLE.
//  ADC sine 128+/-(8<<gain) -> clips at gain 4 -> stored PGA=3 for that ch.
//  ADC const 0 -> DC hits 0, Cal_Error[ch]=1, calibration still completes.
//  OPERATE, NUM_CH=3 -> Sample_Valid every 10 cycles, Sample_Ch 0,1,2,0; settings switch with LED_EN.
//  Find_setting during OPERATE -> Cal_Done=0 next cycle, restart at ch0.

Source files
------------

// File: rtl/ppg_afe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ppg_afe_pkg : shared types, helpers and default thresholds for the   |
// |               PPG AFE calibrator.             Revision: 1.0          |
// +----------------------------------------------------------------------+
package ppg_afe_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SETTLE   = 4'd1,
    ST_DC_ACC   = 4'd2,
    ST_DC_EVAL  = 4'd3,
    ST_PGA_ACC  = 4'd4,
    ST_PGA_EVAL = 4'd5,
    ST_NEXT_CH  = 4'd6,
    ST_OPERATE  = 4'd7
  } cal_state_e;

  localparam int unsigned DEF_DC_LO   = 120;
  localparam int unsigned DEF_DC_HI   = 130;
  localparam int unsigned DEF_CLIP_LO = 10;
  localparam int unsigned DEF_CLIP_HI = 245;

  // Index width for n items, never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    int unsigned w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppg_win_stats.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ppg_win_stats : windowed sum / min / max over a programmable count.  |
// |                                               Revision: 1.0          |
// +----------------------------------------------------------------------+
module ppg_win_stats #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SUM_W  = 13,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [CNT_W-1:0]  win_len,
  input  logic [DATA_W-1:0] sample,
  output logic [SUM_W-1:0]  sum,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] max_val,
  output logic              last
);

  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    sum_d = sum_q;
    min_d = min_q;
    max_d = max_q;
    cnt_d = cnt_q;
    if (clr) begin
      sum_d = '0;
      min_d = '1;
      max_d = '0;
      cnt_d = '0;
    end else if (en) begin
      sum_d = sum_q + SUM_W'(sample);
      if (sample < min_q) min_d = sample;
      if (sample > max_q) max_d = sample;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      min_q <= '1;
      max_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      min_q <= min_d;
      max_q <= max_d;
      cnt_q <= cnt_d;
    end
  end

  assign sum     = sum_q;
  assign min_val = min_q;
  assign max_val = max_q;
  assign last    = en && (cnt_q == (win_len - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/ppg_afe_calibrator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ppg_afe_calibrator : per-channel DC/PGA calibration of a multiplexed |
// |                      LED PPG front end, then round-robin sampling.   |
// |                                               Revision: 1.0          |
// +----------------------------------------------------------------------+
module ppg_afe_calibrator
  import ppg_afe_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ADC_W    = 8,
  parameter int unsigned DC_W     = 7,
  parameter int unsigned PGA_W    = 4,
  parameter int unsigned AVG_LOG2 = 5,
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned PGA_WIN  = 16,
  parameter int unsigned DC_LO    = DEF_DC_LO,
  parameter int unsigned DC_HI    = DEF_DC_HI,
  parameter int unsigned CLIP_LO  = DEF_CLIP_LO,
  parameter int unsigned CLIP_HI  = DEF_CLIP_HI,
  parameter int unsigned SLOT_CYC = 10,
  parameter int unsigned LED_CUR  = 10
) (
  input  logic                         CLK,
  input  logic                         rst_n,
  input  logic [ADC_W-1:0]             ADC,
  input  logic                         Find_setting,
  output logic [3:0]                   LED_DRIVE,
  output logic [NUM_CH-1:0]            LED_EN,
  output logic [DC_W-1:0]              DC_Comp,
  output logic [PGA_W-1:0]             PGA_Gain,
  output logic                         CLK_Filter,
  output logic [ADC_W-1:0]             Sample_Value,
  output logic [idx_w(NUM_CH)-1:0]     Sample_Ch,
  output logic                         Sample_Valid,
  output logic                         Cal_Busy,
  output logic                         Cal_Done,
  output logic [NUM_CH-1:0]            Cal_Error
);

  localparam int unsigned CH_W    = idx_w(NUM_CH);
  localparam int unsigned DC_WIN  = 1 << AVG_LOG2;
  localparam int unsigned WIN_MAX = (DC_WIN > PGA_WIN) ? DC_WIN : PGA_WIN;
  localparam int unsigned CNT_W   = idx_w(WIN_MAX + 1);
  localparam int unsigned SUM_W   = ADC_W + AVG_LOG2;
  localparam int unsigned SC_MAX  = (SETTLE > SLOT_CYC) ? SETTLE : SLOT_CYC;
  localparam int unsigned SC_W    = idx_w(SC_MAX + 1);

  localparam logic [DC_W-1:0]  DC_MID  = DC_W'(1 << (DC_W - 1));
  localparam logic [DC_W-1:0]  DC_MAX  = {DC_W{1'b1}};
  localparam logic [PGA_W-1:0] PGA_MAX = {PGA_W{1'b1}};
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

  cal_state_e state_q, state_d;

  logic              phase_q, phase_d;   // 0: DC search, 1: PGA search
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   slot_q, slot_d;
  logic [SC_W-1:0]   cnt_q, cnt_d;
  logic [DC_W-1:0]   dc_q, dc_d;
  logic [PGA_W-1:0]  pga_q, pga_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic [DC_W-1:0]   dc_mem_q  [NUM_CH];
  logic [DC_W-1:0]   dc_mem_d  [NUM_CH];
  logic [PGA_W-1:0]  pga_mem_q [NUM_CH];
  logic [PGA_W-1:0]  pga_mem_d [NUM_CH];
  logic [ADC_W-1:0]  smp_val_q, smp_val_d;
  logic [CH_W-1:0]   smp_ch_q, smp_ch_d;
  logic              smp_vld_q, smp_vld_d;
  logic              clkf_q;

  logic              stats_clr, stats_en, win_last;
  logic [CNT_W-1:0]  win_len;
  logic [SUM_W-1:0]  win_sum;
  logic [ADC_W-1:0]  win_min, win_max;
  logic [ADC_W-1:0]  dc_avg;
  logic              settle_last, slot_last, clipped, dc_done;
  logic [CH_W-1:0]   slot_nxt;

  assign win_len     = (state_q == ST_PGA_ACC) ? CNT_W'(PGA_WIN) : CNT_W'(DC_WIN);
  assign dc_avg      = ADC_W'(win_sum >> AVG_LOG2);
  assign settle_last = (cnt_q == SC_W'(SETTLE - 1));
  assign slot_last   = (cnt_q == SC_W'(SLOT_CYC - 1));
  assign clipped     = (win_min <= ADC_W'(CLIP_LO)) || (win_max >= ADC_W'(CLIP_HI));

  ppg_win_stats #(
    .DATA_W (ADC_W),
    .SUM_W  (SUM_W),
    .CNT_W  (CNT_W)
  ) u_stats (
    .clk     (CLK),
    .rst_n   (rst_n),
    .clr     (stats_clr),
    .en      (stats_en),
    .win_len (win_len),
    .sample  (ADC),
    .sum     (win_sum),
    .min_val (win_min),
    .max_val (win_max),
    .last    (win_last)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (Find_setting) begin
      state_d = ST_SETTLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_IDLE;
        ST_SETTLE:   if (settle_last) state_d = phase_q ? ST_PGA_ACC : ST_DC_ACC;
        ST_DC_ACC:   if (win_last) state_d = ST_DC_EVAL;
        ST_DC_EVAL:  state_d = ST_SETTLE;
        ST_PGA_ACC:  if (win_last) state_d = ST_PGA_EVAL;
        ST_PGA_EVAL: state_d = (clipped || (pga_q == PGA_MAX)) ? ST_NEXT_CH : ST_SETTLE;
        ST_NEXT_CH:  state_d = (ch_q == LAST_CH) ? ST_OPERATE : ST_SETTLE;
        ST_OPERATE:  state_d = ST_OPERATE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    LED_EN    = '0;
    Cal_Busy  = 1'b0;
    Cal_Done  = 1'b0;
    stats_clr = 1'b0;
    stats_en  = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_OPERATE: begin
        LED_EN   = NUM_CH'(1) << slot_q;
        Cal_Done = 1'b1;
      end
      default: begin
        LED_EN    = NUM_CH'(1) << ch_q;
        Cal_Busy  = 1'b1;
        stats_clr = (state_q == ST_SETTLE);
        stats_en  = (state_q == ST_DC_ACC) || (state_q == ST_PGA_ACC);
      end
    endcase
  end

  always_comb begin
    phase_d   = phase_q;
    ch_d      = ch_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    dc_d      = dc_q;
    pga_d     = pga_q;
    err_d     = err_q;
    dc_mem_d  = dc_mem_q;
    pga_mem_d = pga_mem_q;
    smp_val_d = smp_val_q;
    smp_ch_d  = smp_ch_q;
    smp_vld_d = 1'b0;
    dc_done   = 1'b0;
    slot_nxt  = (slot_q == LAST_CH) ? '0 : slot_q + CH_W'(1);

    if (Find_setting) begin
      phase_d = 1'b0;
      ch_d    = '0;
      cnt_d   = '0;
      dc_d    = DC_MID;
      pga_d   = '0;
      err_d   = '0;
    end else begin
      case (state_q)
        ST_SETTLE: cnt_d = settle_last ? '0 : cnt_q + SC_W'(1);
        ST_DC_EVAL: begin
          // A step beyond either end of the DAC range ends the search with an error flag.
          if (dc_avg < ADC_W'(DC_LO)) begin
            if (dc_q == '0) begin
              err_d[ch_q] = 1'b1;
              dc_done     = 1'b1;
            end else begin
              dc_d = dc_q - DC_W'(1);
            end
          end else if (dc_avg > ADC_W'(DC_HI)) begin
            if (dc_q == DC_MAX) begin
              err_d[ch_q] = 1'b1;
              dc_done     = 1'b1;
            end else begin
              dc_d = dc_q + DC_W'(1);
            end
          end else begin
            dc_done = 1'b1;
          end
          if (dc_done) begin
            dc_mem_d[ch_q] = dc_q;
            pga_d          = '0;
            phase_d        = 1'b1;
          end
        end
        ST_PGA_EVAL: begin
          if (clipped) begin
            pga_mem_d[ch_q] = (pga_q == '0) ? '0 : pga_q - PGA_W'(1);
          end else if (pga_q == PGA_MAX) begin
            pga_mem_d[ch_q] = pga_q;
          end else begin
            pga_d = pga_q + PGA_W'(1);
          end
        end
        ST_NEXT_CH: begin
          cnt_d = '0;
          if (ch_q == LAST_CH) begin
            slot_d = '0;
            dc_d   = dc_mem_q[0];
            pga_d  = pga_mem_q[0];
          end else begin
            // Each channel starts its DC search from mid-scale at unity gain.
            ch_d    = ch_q + CH_W'(1);
            phase_d = 1'b0;
            dc_d    = DC_MID;
            pga_d   = '0;
          end
        end
        ST_OPERATE: begin
          if (slot_last) begin
            cnt_d     = '0;
            smp_val_d = ADC;
            smp_ch_d  = slot_q;
            smp_vld_d = 1'b1;
            slot_d    = slot_nxt;
            dc_d      = dc_mem_q[slot_nxt];
            pga_d     = pga_mem_q[slot_nxt];
          end else begin
            cnt_d = cnt_q + SC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= 1'b0;
      ch_q      <= '0;
      slot_q    <= '0;
      cnt_q     <= '0;
      dc_q      <= '0;
      pga_q     <= '0;
      err_q     <= '0;
      dc_mem_q  <= '{default: '0};
      pga_mem_q <= '{default: '0};
      smp_val_q <= '0;
      smp_ch_q  <= '0;
      smp_vld_q <= 1'b0;
      clkf_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      ch_q      <= ch_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      dc_q      <= dc_d;
      pga_q     <= pga_d;
      err_q     <= err_d;
      dc_mem_q  <= dc_mem_d;
      pga_mem_q <= pga_mem_d;
      smp_val_q <= smp_val_d;
      smp_ch_q  <= smp_ch_d;
      smp_vld_q <= smp_vld_d;
      clkf_q    <= ~clkf_q;
    end
  end

  assign LED_DRIVE    = 4'(LED_CUR);
  assign DC_Comp      = dc_q;
  assign PGA_Gain     = pga_q;
  assign CLK_Filter   = clkf_q;
  assign Sample_Value = smp_val_q;
  assign Sample_Ch    = smp_ch_q;
  assign Sample_Valid = smp_vld_q;
  assign Cal_Error    = err_q;

endmodule
`default_nettype wire
